// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised register-file FIFO: widths, pointer
// wrapping and a sanity check on the programmable level parameters.
package fifo_pkg;

  function automatic int unsigned fn_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Explicit wrap at depth-1 so non-power-of-two depths index correctly.
  function automatic int unsigned fn_wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  function automatic bit fn_levels_ok(input int unsigned ae, input int unsigned af,
                                      input int unsigned depth);
    return (ae < af) && (af <= depth);
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// Storage array: synchronous write, combinational (show-ahead) read, no reset.
module fifo_regfile
  import fifo_pkg::*;
#(
  parameter int unsigned pBITS  = 8,
  parameter int unsigned pDEPTH = 6
) (
  input  logic                          iclk,
  input  logic                          i_we,
  input  logic [fn_width(pDEPTH)-1:0]   i_waddr,
  input  logic [pBITS-1:0]              i_wdata,
  input  logic [fn_width(pDEPTH)-1:0]   i_raddr,
  output logic [pBITS-1:0]              o_rdata
);

  logic [pBITS-1:0] r_mem [pDEPTH];

  always_ff @(posedge iclk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_param_lvl.sv
// Single-clock FIFO with arbitrary depth, exact fill count, registered
// almost-full/almost-empty flags, sticky overflow/underflow and a sync flush.
module fifo_param_lvl
  import fifo_pkg::*;
#(
  parameter int unsigned pBITS     = 8,
  parameter int unsigned pDEPTH    = 6,
  parameter int unsigned pAF_LEVEL = 5,
  parameter int unsigned pAE_LEVEL = 1
) (
  input  logic                         iclk,
  input  logic                         ireset,
  input  logic                         iflush,
  input  logic                         iclr_err,
  input  logic                         iwr,
  input  logic [pBITS-1:0]             iw_data,
  input  logic                         ird,
  output logic [pBITS-1:0]             or_data,
  output logic                         oempty,
  output logic                         ofull,
  output logic                         oalmost_empty,
  output logic                         oalmost_full,
  output logic [$clog2(pDEPTH+1)-1:0]  ocount,
  output logic                         ooverflow,
  output logic                         ounderflow
);

  localparam int unsigned PW = fn_width(pDEPTH);
  localparam int unsigned CW = $clog2(pDEPTH + 1);
  localparam bit LEVELS_OK = fn_levels_ok(pAE_LEVEL, pAF_LEVEL, pDEPTH);

  generate
    if (!LEVELS_OK) begin : g_bad_levels
      $error("fifo_param_lvl: need pAE_LEVEL < pAF_LEVEL <= pDEPTH");
    end
  endgenerate

  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_empty, r_full, r_aempty, r_afull, r_ovf, r_udf;

  logic          w_wr_acc, w_rd_acc, w_we, w_ovf_evt, w_udf_evt;
  logic [CW-1:0] w_count_nxt;
  logic [PW-1:0] w_wptr_inc, w_rptr_inc;

  // A write into a full FIFO is accepted when a read frees the head slot.
  assign w_wr_acc    = iwr & (~r_full | ird);
  assign w_rd_acc    = ird & ~r_empty;
  assign w_we        = w_wr_acc & ~iflush;
  assign w_ovf_evt   = iwr & ~w_wr_acc & ~iflush;
  assign w_udf_evt   = ird & r_empty & ~iflush;
  assign w_count_nxt = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
  assign w_wptr_inc  = PW'(fn_wrap_inc(32'(r_wptr), pDEPTH));
  assign w_rptr_inc  = PW'(fn_wrap_inc(32'(r_rptr), pDEPTH));

  fifo_regfile #(
    .pBITS (pBITS),
    .pDEPTH(pDEPTH)
  ) u_regfile (
    .iclk   (iclk),
    .i_we   (w_we),
    .i_waddr(r_wptr),
    .i_wdata(iw_data),
    .i_raddr(r_rptr),
    .o_rdata(or_data)
  );

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_aempty <= 1'b1;
      r_afull  <= (pAF_LEVEL == 0);
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_ovf <= w_ovf_evt | (r_ovf & ~iclr_err);
      r_udf <= w_udf_evt | (r_udf & ~iclr_err);
      if (iflush) begin
        r_wptr   <= '0;
        r_rptr   <= '0;
        r_count  <= '0;
        r_empty  <= 1'b1;
        r_full   <= 1'b0;
        r_aempty <= 1'b1;
        r_afull  <= (pAF_LEVEL == 0);
      end else begin
        if (w_wr_acc) r_wptr <= w_wptr_inc;
        if (w_rd_acc) r_rptr <= w_rptr_inc;
        r_count  <= w_count_nxt;
        r_empty  <= (w_count_nxt == '0);
        r_full   <= (w_count_nxt == CW'(pDEPTH));
        r_aempty <= (w_count_nxt <= CW'(pAE_LEVEL));
        r_afull  <= (w_count_nxt >= CW'(pAF_LEVEL));
      end
    end
  end

  assign oempty        = r_empty;
  assign ofull         = r_full;
  assign oalmost_empty = r_aempty;
  assign oalmost_full  = r_afull;
  assign ocount        = r_count;
  assign ooverflow     = r_ovf;
  assign ounderflow    = r_udf;

endmodule

// File: tb/tb_fifo_param_lvl.sv
// Scoreboard bench for fifo_param_lvl: a queue holds the expected contents.
module tb_fifo_param_lvl;

  localparam int unsigned BITS = 8;
  localparam int unsigned D    = 6;
  localparam int unsigned AF   = 5;
  localparam int unsigned AE   = 1;

  logic            iclk = 1'b0;
  logic            ireset, iflush, iclr_err, iwr, ird;
  logic [BITS-1:0] iw_data, or_data;
  logic            oempty, ofull, oalmost_empty, oalmost_full, ooverflow, ounderflow;
  logic [2:0]      ocount;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  logic [BITS-1:0] q[$];
  logic m_ovf = 1'b0;
  logic m_udf = 1'b0;

  always #5 iclk = ~iclk;

  fifo_param_lvl #(
    .pBITS    (BITS),
    .pDEPTH   (D),
    .pAF_LEVEL(AF),
    .pAE_LEVEL(AE)
  ) dut (
    .iclk         (iclk),
    .ireset       (ireset),
    .iflush       (iflush),
    .iclr_err     (iclr_err),
    .iwr          (iwr),
    .iw_data      (iw_data),
    .ird          (ird),
    .or_data      (or_data),
    .oempty       (oempty),
    .ofull        (ofull),
    .oalmost_empty(oalmost_empty),
    .oalmost_full (oalmost_full),
    .ocount       (ocount),
    .ooverflow    (ooverflow),
    .ounderflow   (ounderflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    int unsigned n;
    n = q.size();
    chk("count",  32'(ocount), n);
    chk("empty",  32'(oempty), 32'(n == 0));
    chk("full",   32'(ofull),  32'(n == D));
    chk("aempty", 32'(oalmost_empty), 32'(n <= AE));
    chk("afull",  32'(oalmost_full),  32'(n >= AF));
    chk("ovf",    32'(ooverflow),  32'(m_ovf));
    chk("udf",    32'(ounderflow), 32'(m_udf));
    if (n > 0) chk("head", 32'(or_data), 32'(q[0]));
  endtask

  task automatic step(input logic wr, input logic rd, input logic [BITS-1:0] d,
                      input logic fl, input logic clr);
    logic wacc, racc, eo, eu;
    iwr = wr; ird = rd; iw_data = d; iflush = fl; iclr_err = clr;
    wacc = wr && ((q.size() < D) || rd);
    racc = rd && (q.size() > 0);
    eo   = wr && !wacc && !fl;
    eu   = rd && (q.size() == 0) && !fl;
    if (racc && !fl) chk("pop", 32'(or_data), 32'(q[0]));
    @(posedge iclk);
    #1;
    iwr = 1'b0; ird = 1'b0; iflush = 1'b0; iclr_err = 1'b0;
    if (fl) q.delete();
    else begin
      if (racc) void'(q.pop_front());
      if (wacc) q.push_back(d);
    end
    m_ovf = eo || (m_ovf && !clr);
    m_udf = eu || (m_udf && !clr);
    check_state();
  endtask

  task automatic wr(input logic [BITS-1:0] d); step(1'b1, 1'b0, d, 1'b0, 1'b0); endtask
  task automatic rd();                         step(1'b0, 1'b1, '0, 1'b0, 1'b0); endtask

  initial begin
    ireset = 1'b1; iflush = 1'b0; iclr_err = 1'b0; iwr = 1'b0; ird = 1'b0; iw_data = '0;
    repeat (2) @(posedge iclk);
    #1;
    check_state();
    ireset = 1'b0;

    // basic
    wr(8'hA1); wr(8'hA2); wr(8'hA3);
    repeat (3) rd();

    // fill and wrap
    for (int unsigned i = 0; i < 6; i++) wr(8'(8'h10 + i));
    repeat (4) rd();
    for (int unsigned i = 0; i < 4; i++) wr(8'(8'h16 + i));

    // full + simultaneous read/write, then overflow
    step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
    wr(8'h77);
    repeat (6) rd();

    // empty + simultaneous read/write
    step(1'b1, 1'b1, 8'h66, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // clear concurrent with a new overflow
    for (int unsigned i = 0; i < 5; i++) wr(8'(8'h80 + i));
    step(1'b1, 1'b0, 8'hEE, 1'b0, 1'b1);

    // flush with write pending; errors persist
    repeat (2) rd();
    step(1'b1, 1'b0, 8'h99, 1'b1, 1'b0);
    rd();
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // async reset between edges
    wr(8'hC1); wr(8'hC2); wr(8'hC3);
    rd(); rd(); rd(); rd();
    wr(8'hC4); wr(8'hC5); wr(8'hC6);
    #2;
    ireset = 1'b1;
    #1;
    q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    check_state();
    @(negedge iclk);
    ireset = 1'b0;

    // mixed traffic
    for (int unsigned i = 0; i < 80; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_param_lvl.md
Name: fifo_param_lvl

Overview:
Parametrised successor to the team's synchronous register-file FIFO. It supports arbitrary (non-power-of-two) depth and keeps an exact fill count with programmable almost-full/almost-empty flags. It also adds sticky overflow/underflow error flags, a synchronous flush, and correct simultaneous read/write handling at the empty and full boundaries. It is a drop-in buffer between single-clock producer/consumer stages.

Parameters:
pBITS, 8, data word width (>=1)
pDEPTH, 6, number of entries (>=2, any integer, need not be a power of two)
pAF_LEVEL, 5, oalmost_full asserted when count >= pAF_LEVEL (1..pDEPTH)
pAE_LEVEL, 1, oalmost_empty asserted when count <= pAE_LEVEL (0..pDEPTH-1)

Ports:
iclk  in  1  clock, all state updates on rising edge
ireset  in  1  reset, asynchronous, active-high
iflush  in  1  synchronous flush: empty the FIFO
iclr_err  in  1  synchronous clear of sticky error flags
iwr  in  1  write request
iw_data  in  pBITS  write data
ird  in  1  read request (pops the current or_data)
or_data  out  pBITS  head-of-queue data (show-ahead), valid when oempty=0
oempty  out  1  FIFO empty
ofull  out  1  FIFO full
oalmost_empty  out  1  count <= pAE_LEVEL
oalmost_full  out  1  count >= pAF_LEVEL
ocount  out  $clog2(pDEPTH+1)  current fill level, 0..pDEPTH
ooverflow  out  1  sticky: write attempted while full and not accepted
ounderflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (async, ireset=1): write/read pointers=0, count=0, oempty=1, ofull=0, oalmost_empty=1, oalmost_full=(pAF_LEVEL==0 ? 1 : 0) (effectively 0), ooverflow=0, ounderflow=0. Storage contents are not reset. Reset mid-operation discards all queued data immediately.
- Pointers: width $clog2(pDEPTH). Increment wraps pDEPTH-1 -> 0 explicitly; no reliance on binary rollover.
- Flags are registered and derived from next-count: oempty=(count==0), ofull=(count==pDEPTH), almost flags by comparison. They are never inferred from pointer equality.
- Accept rules per cycle:
  - wr_acc = iwr & (~ofull | ird)
  - rd_acc = ird & ~oempty
- Both accepted: both pointers advance, count unchanged.
- Full + iwr + ird: both are accepted. The written word lands in the slot being vacated; or_data shows the old head this cycle.
- Empty + iwr + ird: only the write is accepted; the read is ignored and ounderflow sets.
- Write latency: a word written at edge N appears on or_data after edge N when the FIFO was empty (oempty falls at the same edge).
- or_data is combinational from storage at the read pointer. It is undefined/stale while oempty=1.
- Error flags:
  - ooverflow sets at the edge where iwr=1 and wr_acc=0.
  - ounderflow sets at the edge where ird=1 and oempty=1.
  - Both hold until iclr_err or reset.
  - iclr_err has lower priority than a new error event in the same cycle (the flag stays 1).
- iflush: pointers=0, count=0, flags as reset. Simultaneous iwr/ird in that cycle are ignored and raise no errors. Error flags are unaffected by flush.
- Priority: ireset > iflush > rd/wr.

Decomposition:
- Package fifo_pkg: function for pointer/count width (clog2-based), a wrapping-increment function taking a depth argument, and a localparam check that pAE_LEVEL < pAF_LEVEL <= pDEPTH, with an elaboration error otherwise.
- One sub-module, fifo_regfile (pBITS, pDEPTH): synchronous write port (we, waddr, wdata) and combinational read port (raddr, rdata), with no reset.
- Control, count, flags, and error logic live in the top module.

Test Plan:
- Reset/basic: ireset pulse, then write 0xA1,0xA2,0xA3, then read 3 -> or_data sequence A1,A2,A3; ocount 1,2,3,2,1,0; oempty=1 at end; no error flags.
- Fill/wrap (pDEPTH=6): write 6 words 0x10..0x15 -> ofull=1, ocount=6, oalmost_full from count 5. Read 4, write 4 (0x16..0x19) -> pointers wrap past 5->0; reads return 0x14..0x19 in order.
- Boundary simultaneity: when full, iwr=ird=1 with 0x55 -> count stays 6, ofull=1, popped word is the old head, and 0x55 later emerges last. When empty, iwr=ird=1 with 0x66 -> count=1, ounderflow=1, or_data=0x66.
- Errors: write 7th word when full -> ooverflow=1 and the word is not stored. Read when empty -> ounderflow=1. iclr_err -> both 0. iclr_err concurrent with a new overflow -> ooverflow remains 1.
- Flush: with 4 words queued, assert iflush with iwr=1 -> ocount=0, oempty=1, no write stored, error flags unchanged.
- Async reset mid-traffic: assert ireset between clock edges while ocount=3 -> all outputs return to reset values immediately, without waiting for an edge.
